// File: rtl/ahb_lite_interconnect_pkg.sv
// Shared definitions for the AHB-Lite interconnect: HTRANS encodings,
// HRESP codes, the default slave address map and the default-slave FSM states.
package ahb_lite_interconnect_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam int DEF_SLAVES = 16;

  // HADDR[31:16] match value per slot, slot 0 in the least significant 16 bits.
  localparam logic [DEF_SLAVES*16-1:0] DEFAULT_SLAVE_BASE = {
    16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000,            // slots 15..11
    16'h6007, 16'h6006, 16'h6005, 16'h6004,                      // slots 10..7
    16'h6003, 16'h6002, 16'h6001, 16'h6000,                      // slots 6..3
    16'h4000, 16'h2000, 16'h0000                                 // slots 2..0
  };

  typedef enum logic [1:0] {
    DS_IDLE,
    DS_ERR1,
    DS_ERR2
  } dslv_state_e;

endpackage

// File: rtl/ahb_default_slave.sv
// Default slave: answers unmapped NONSEQ/SEQ transfers with the two-cycle
// AHB ERROR response. Optional wait-state watchdog (macro AHB_ICT_TIMEOUT_EN)
// aborts a stalled slave with the same ERROR sequence and raises a sticky flag.
module ahb_default_slave
  import ahb_lite_interconnect_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic hready,       // muxed HREADY seen by the master
  input  logic xfer_req,     // HTRANS[1]: NONSEQ or SEQ in the address phase
  input  logic addr_hit,     // some enabled slot decodes the address
  input  logic slave_wait,   // registered slot selected and holding HREADYOUT low
  output logic err_active,   // FSM owns the response (ERR1 or ERR2)
  output logic err_ready,    // HREADY value while err_active
  output logic timeout_flag
);

  dslv_state_e state_q, state_d;
  logic        unmapped;
  logic        timeout_hit;

`ifdef AHB_ICT_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wait_cnt;

  // Abort in the cycle that completes the TIMEOUT_CYCLES-th wait state.
  assign timeout_hit = (state_q == DS_IDLE) && slave_wait &&
                       (wait_cnt == CW'(TIMEOUT_CYCLES - 1));

  // Wait-state counter and sticky abort flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt     <= '0;
      timeout_flag <= 1'b0;
    end else begin
      if (hready || state_q != DS_IDLE) wait_cnt <= '0;
      else if (slave_wait)              wait_cnt <= wait_cnt + CW'(1);
      if (timeout_hit) timeout_flag <= 1'b1;
    end
  end
`else
  assign timeout_hit  = 1'b0;
  assign timeout_flag = 1'b0;

  logic unused_timeout_cfg;
  assign unused_timeout_cfg = slave_wait ^ (TIMEOUT_CYCLES != 0);
`endif

  assign unmapped = hready && xfer_req && !addr_hit;

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every flop
    // samples the pre-edge value regardless of block ordering.
    if (rst) state_q <= DS_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_d unassigned,
    // which would infer a latch.
    state_d = state_q;
    case (state_q)
      DS_IDLE: if (unmapped || timeout_hit) state_d = DS_ERR1;
      DS_ERR1: state_d = DS_ERR2;
      DS_ERR2: state_d = unmapped ? DS_ERR1 : DS_IDLE;
      default: state_d = DS_IDLE;
    endcase
  end

  assign err_active = (state_q != DS_IDLE);
  assign err_ready  = (state_q == DS_ERR2);

endmodule

// File: rtl/ahb_lite_interconnect.sv
// AHB-Lite single-master interconnect: combinational address decode to a
// one-hot slave select, registered data-phase select, response mux and a
// default slave for unmapped transfers.
// Optional feature: define AHB_ICT_TIMEOUT_EN to enable the wait-state timeout.
module ahb_lite_interconnect
  import ahb_lite_interconnect_pkg::*;
#(
  parameter int                              SLAVES_EXP     = 4,
  parameter logic [(2**SLAVES_EXP)*16-1:0]   SLAVE_BASE     = DEFAULT_SLAVE_BASE,
  parameter logic [(2**SLAVES_EXP)-1:0]      SLAVE_VALID    = 16'h07FF,
  parameter int                              TIMEOUT_CYCLES = 16
) (
  input  logic                             HCLK,
  input  logic                             HRESET,
  input  logic [31:0]                      HADDR,
  input  logic [1:0]                       HTRANS,
  output logic [(2**SLAVES_EXP)-1:0]       HSEL_A,
  output logic [SLAVES_EXP-1:0]            HSEL_ENCODE,
  input  logic [(2**SLAVES_EXP)*32-1:0]    HRDATA_S,
  input  logic [(2**SLAVES_EXP)-1:0]       HREADYOUT_S,
  input  logic [(2**SLAVES_EXP)-1:0]       HRESP_S,
  output logic [31:0]                      HRDATA,
  output logic                             HREADY,
  output logic                             HRESP,
  output logic                             TIMEOUT_FLAG
);

  localparam int N = 2**SLAVES_EXP;

  logic [SLAVES_EXP-1:0] hit_idx;
  logic                  any_match;
  logic [SLAVES_EXP-1:0] sel_idx;
  logic                  sel_valid;
  logic                  slot_ready;
  logic                  slot_resp;
  logic [31:0]           slot_data;
  logic                  err_active;
  logic                  err_ready;

  // Address decode; scanning from the top down leaves the lowest matching slot.
  always_comb begin
    hit_idx   = '0;
    any_match = 1'b0;
    HSEL_A    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (SLAVE_VALID[i] && HADDR[31:16] == SLAVE_BASE[16*i +: 16]) begin
        hit_idx   = SLAVES_EXP'(i);
        any_match = 1'b1;
      end
    end
    if (any_match) HSEL_A[hit_idx] = 1'b1;
  end

  assign HSEL_ENCODE = hit_idx;

  // Data-phase select: captures the address phase only when it completes.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      sel_idx   <= '0;
      sel_valid <= 1'b0;
    end else if (HREADY) begin
      sel_idx   <= hit_idx;
      sel_valid <= HTRANS[1] && any_match;
    end
  end

  assign slot_ready = HREADYOUT_S[sel_idx];
  assign slot_resp  = HRESP_S[sel_idx];
  assign slot_data  = HRDATA_S[32*sel_idx +: 32];

  // Response mux: default slave overrides, else registered slot, else idle OKAY.
  always_comb begin
    HREADY = 1'b1;
    HRESP  = HRESP_OKAY;
    HRDATA = '0;
    if (err_active) begin
      HREADY = err_ready;
      HRESP  = HRESP_ERROR;
    end else if (sel_valid) begin
      HREADY = slot_ready;
      HRESP  = slot_resp;
      HRDATA = slot_data;
    end
  end

  ahb_default_slave #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_default_slave (
    .clk          (HCLK),
    .rst          (HRESET),
    .hready       (HREADY),
    .xfer_req     (HTRANS[1]),
    .addr_hit     (any_match),
    .slave_wait   (sel_valid && !slot_ready),
    .err_active   (err_active),
    .err_ready    (err_ready),
    .timeout_flag (TIMEOUT_FLAG)
  );

  // Low address bits and the SEQ/NONSEQ distinction play no part in routing.
  logic unused_inputs;
  assign unused_inputs = ^{HTRANS[0], HADDR[15:0]};

endmodule

// File: tb/tb_ahb_lite_interconnect.sv
// Directed bench for ahb_lite_interconnect: a driver applies one cycle of
// stimulus per step and queues the hand-computed outputs for that cycle;
// a monitor pops and compares on every falling edge.
module tb_ahb_lite_interconnect;
  import ahb_lite_interconnect_pkg::*;

  localparam int N = 16;
  localparam logic [1:0] NS = HTRANS_NONSEQ;
  localparam logic [1:0] ID = HTRANS_IDLE;

  logic            HCLK = 1'b0;
  logic            HRESET;
  logic [31:0]     HADDR;
  logic [1:0]      HTRANS;
  logic [N-1:0]    HSEL_A;
  logic [3:0]      HSEL_ENCODE;
  logic [N*32-1:0] HRDATA_S;
  logic [N-1:0]    HREADYOUT_S;
  logic [N-1:0]    HRESP_S;
  logic [31:0]     HRDATA;
  logic            HREADY;
  logic            HRESP;
  logic            TIMEOUT_FLAG;

  always #5 HCLK = ~HCLK;

  ahb_lite_interconnect #(.TIMEOUT_CYCLES(16)) dut (
    .HCLK         (HCLK),
    .HRESET       (HRESET),
    .HADDR        (HADDR),
    .HTRANS       (HTRANS),
    .HSEL_A       (HSEL_A),
    .HSEL_ENCODE  (HSEL_ENCODE),
    .HRDATA_S     (HRDATA_S),
    .HREADYOUT_S  (HREADYOUT_S),
    .HRESP_S      (HRESP_S),
    .HRDATA       (HRDATA),
    .HREADY       (HREADY),
    .HRESP        (HRESP),
    .TIMEOUT_FLAG (TIMEOUT_FLAG)
  );

  typedef struct {
    string       name;
    logic [15:0] sel;
    logic [3:0]  enc;
    logic        rdy;
    logic        resp;
    logic [31:0] data;
    logic        flag;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  // Apply one cycle of stimulus just after the rising edge and queue the
  // outputs expected during that same cycle.
  task automatic step(input string name, input logic rst, input logic [31:0] addr,
                      input logic [1:0] trans, input logic [15:0] sel, input logic [3:0] enc,
                      input logic rdy, input logic resp, input logic [31:0] data,
                      input logic flag, input logic [15:0] rdy_s = 16'hFFFF,
                      input logic [15:0] resp_s = 16'h0000);
    exp_t e;
    @(posedge HCLK);
    #1;
    HRESET      = rst;
    HADDR       = addr;
    HTRANS      = trans;
    HREADYOUT_S = rdy_s;
    HRESP_S     = resp_s;
    e.name = name; e.sel = sel; e.enc = enc;
    e.rdy  = rdy;  e.resp = resp; e.data = data; e.flag = flag;
    sb.push_back(e);
  endtask

  // Monitor: compare every queued expectation on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge HCLK);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        total++;
        if (HSEL_A !== e.sel || HSEL_ENCODE !== e.enc || HREADY !== e.rdy ||
            HRESP !== e.resp || HRDATA !== e.data || TIMEOUT_FLAG !== e.flag) begin
          bad++;
          $display("FAIL %s: got sel=%h enc=%0d rdy=%b resp=%b data=%h flag=%b, want sel=%h enc=%0d rdy=%b resp=%b data=%h flag=%b",
                   e.name, HSEL_A, HSEL_ENCODE, HREADY, HRESP, HRDATA, TIMEOUT_FLAG,
                   e.sel, e.enc, e.rdy, e.resp, e.data, e.flag);
        end
      end
    end
  end

  // Watchdog so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    HRESET      = 1'b1;
    HADDR       = '0;
    HTRANS      = ID;
    HREADYOUT_S = '1;
    HRESP_S     = '0;
    for (int i = 0; i < N; i++) HRDATA_S[32*i +: 32] = 32'hA000_0000 + 32'(i);
    HRDATA_S[63:32] = 32'hDEAD_BEEF;
    repeat (2) @(posedge HCLK);

    //   name               rst addr          tr  sel       enc  rdy resp data          flag
    step("rst_sel_follows", 1, 32'h4000_0000, NS, 16'h0004, 2,  1, 0, 32'h0,         0);
    step("rst_idle",        0, 32'h2000_0010, NS, 16'h0002, 1,  1, 0, 32'h0,         0);
    step("read_slot1",      0, 32'h8000_0000, NS, 16'h0000, 0,  1, 0, 32'hDEAD_BEEF, 0);
    step("err1",            0, 32'h0000_0004, ID, 16'h0001, 0,  0, 1, 32'h0,         0);
    step("err2",            0, 32'h0000_0004, ID, 16'h0001, 0,  1, 1, 32'h0,         0);
    step("err_done",        0, 32'h8000_0000, ID, 16'h0000, 0,  1, 0, 32'h0,         0);
    step("idle_unmapped",   0, 32'h6000_0000, NS, 16'h0008, 3,  1, 0, 32'h0,         0);
    step("wait1",           0, 32'h0000_0004, NS, 16'h0001, 0,  0, 0, 32'hA000_0003, 0, 16'hFFF7);
    step("wait2",           0, 32'h0000_0004, NS, 16'h0001, 0,  0, 0, 32'hA000_0003, 0, 16'hFFF7);
    step("wait3",           0, 32'h0000_0004, NS, 16'h0001, 0,  0, 0, 32'hA000_0003, 0, 16'hFFF7);
    step("wait_end",        0, 32'h0000_0004, NS, 16'h0001, 0,  1, 0, 32'hA000_0003, 0);
    step("after_wait",      0, 32'h4000_0000, NS, 16'h0004, 2,  1, 0, 32'hA000_0000, 0);
    step("slave_err",       0, 32'h0000_0000, ID, 16'h0001, 0,  1, 1, 32'hA000_0002, 0, 16'hFFFF, 16'h0004);
    step("pre_wait",        0, 32'h6000_0000, NS, 16'h0008, 3,  1, 0, 32'h0,         0);
    step("wait_pre_rst",    0, 32'h0000_0000, ID, 16'h0001, 0,  0, 0, 32'hA000_0003, 0, 16'hFFF7);
    step("rst_in_wait",     1, 32'h0000_0000, ID, 16'h0001, 0,  0, 0, 32'hA000_0003, 0, 16'hFFF7);
    step("post_rst_wait",   0, 32'h8000_0000, NS, 16'h0000, 0,  1, 0, 32'h0,         0, 16'hFFF7);
    step("rst_in_err1",     1, 32'h0000_0000, ID, 16'h0001, 0,  0, 1, 32'h0,         0);
    step("post_rst_err",    0, 32'h8000_0000, NS, 16'h0000, 0,  1, 0, 32'h0,         0);
    step("b2b_err1",        0, 32'h9000_0000, NS, 16'h0000, 0,  0, 1, 32'h0,         0);
    step("b2b_err2",        0, 32'h8000_0000, NS, 16'h0000, 0,  1, 1, 32'h0,         0);
    step("b2b_err1_again",  0, 32'h2000_0010, NS, 16'h0002, 1,  0, 1, 32'h0,         0);
    step("b2b_err2_again",  0, 32'h2000_0010, NS, 16'h0002, 1,  1, 1, 32'h0,         0);
    step("read_after_err",  0, 32'h6007_0000, ID, 16'h0400, 10, 1, 0, 32'hDEAD_BEEF, 0);
    step("beyond_last",     0, 32'h6008_0000, ID, 16'h0000, 0,  1, 0, 32'h0,         0);

    // Slot 2 never becomes ready.
    step("slot2_addr",      0, 32'h4000_0000, NS, 16'h0004, 2,  1, 0, 32'h0,         0, 16'hFFFB);
    for (int i = 0; i < 16; i++)
      step("wait_slot2",    0, 32'h0000_0000, ID, 16'h0001, 0,  0, 0, 32'hA000_0002, 0, 16'hFFFB);
`ifdef AHB_ICT_TIMEOUT_EN
    step("to_err1",         0, 32'h0000_0000, ID, 16'h0001, 0,  0, 1, 32'h0,         1, 16'hFFFB);
    step("to_err2",         0, 32'h0000_0000, ID, 16'h0001, 0,  1, 1, 32'h0,         1, 16'hFFFB);
    step("to_after",        0, 32'h0000_0000, ID, 16'h0001, 0,  1, 0, 32'h0,         1, 16'hFFFB);
    step("to_rst",          1, 32'h0000_0000, ID, 16'h0001, 0,  1, 0, 32'h0,         1);
    step("to_cleared",      0, 32'h0000_0000, ID, 16'h0001, 0,  1, 0, 32'h0,         0);
`else
    for (int i = 0; i < 4; i++)
      step("wait_unbounded",0, 32'h0000_0000, ID, 16'h0001, 0,  0, 0, 32'hA000_0002, 0, 16'hFFFB);
    step("rst_unbounded",   1, 32'h0000_0000, ID, 16'h0001, 0,  0, 0, 32'hA000_0002, 0, 16'hFFFB);
    step("post_rst_unbnd",  0, 32'h0000_0000, ID, 16'h0001, 0,  1, 0, 32'h0,         0);
`endif

    repeat (2) @(negedge HCLK);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
